// File: rtl/fe_mul_share_arb.sv
// fe_mul_share_arb: round-robin sharing of one fe_mulx among N field-element clients
module fe_mul_share_arb #(
    parameter int N_CLIENTS = 4,
    parameter int W         = 320,
    parameter int CW        = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [N_CLIENTS-1:0]   i_req_valid,
    input  logic [N_CLIENTS*W-1:0] i_req_op_a,
    input  logic [N_CLIENTS*W-1:0] i_req_op_b,
    output logic [N_CLIENTS-1:0]   o_req_done,
    output logic [W-1:0]           o_req_res,
    output logic [W-1:0]           o_mul_op_a,
    output logic [W-1:0]           o_mul_op_b,
    output logic                   o_mul_valid,
    input  logic [W-1:0]           i_mul_res,
    input  logic                   i_mul_done,
    output logic                   o_busy,
    output logic [CW-1:0]          o_owner,
    output logic                   o_err
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
    state_t                 r_state, w_next;
    logic [N_CLIENTS-1:0]   r_pending, r_req_done, w_clr;
    logic [W-1:0]           r_cap_a [N_CLIENTS];
    logic [W-1:0]           r_cap_b [N_CLIENTS];
    logic [W-1:0]           r_req_res;
    logic [CW-1:0]          r_rr, r_owner, w_grant, w_idx;
    logic                   r_err, w_found, w_complete;

    // search pending clients upward from rr+1 with wrap-around; first hit wins
    always_comb begin
        w_found = 1'b0;
        w_grant = '0;
        w_idx   = '0;
        for (int k = 1; k <= N_CLIENTS; k++) begin
            w_idx = CW'((int'(r_rr) + k) % N_CLIENTS);
            if (!w_found && r_pending[w_idx]) begin
                w_found = 1'b1;
                w_grant = w_idx;
            end
        end
    end

    // next state and multiplier-side outputs; operands stay stable across ISSUE and WAIT
    always_comb begin
        w_complete  = (r_state == WAIT) && i_mul_done;
        w_clr       = w_complete ? (N_CLIENTS'(1) << r_owner) : '0;
        w_next      = (r_state == IDLE)  ? (w_found ? ISSUE : IDLE) :
                      (r_state == ISSUE) ? WAIT :
                      (i_mul_done ? IDLE : WAIT);
        o_busy      = (r_state != IDLE);
        o_mul_valid = (r_state == ISSUE);
        o_mul_op_a  = o_busy ? r_cap_a[r_owner] : '0;
        o_mul_op_b  = o_busy ? r_cap_b[r_owner] : '0;
    end

    // state register
    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) r_state <= IDLE;
        else          r_state <= w_next;

    // pending bits and operand capture; a request while already pending is dropped
    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) begin
            r_pending <= '0;
            for (int i = 0; i < N_CLIENTS; i++) begin
                r_cap_a[i] <= '0;
                r_cap_b[i] <= '0;
            end
        end else begin
            r_pending <= (r_pending & ~w_clr) | (i_req_valid & ~r_pending);
            for (int i = 0; i < N_CLIENTS; i++)
                if (i_req_valid[i] && !r_pending[i]) begin
                    r_cap_a[i] <= i_req_op_a[i*W +: W];
                    r_cap_b[i] <= i_req_op_b[i*W +: W];
                end
        end

    // grant, rotation pointer, result return and sticky protocol error
    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) begin
            r_owner    <= '0;
            r_rr       <= CW'(N_CLIENTS - 1);
            r_req_res  <= '0;
            r_req_done <= '0;
            r_err      <= 1'b0;
        end else begin
            if (r_state == IDLE && w_found) r_owner <= w_grant;
            if (w_complete) begin
                r_rr      <= r_owner;
                r_req_res <= i_mul_res;
            end
            r_req_done <= w_clr;
            if (|(i_req_valid & r_pending) || (i_mul_done && r_state != WAIT)) r_err <= 1'b1;
        end

    assign o_req_done = r_req_done;
    assign o_req_res  = r_req_res;
    assign o_owner    = r_owner;
    assign o_err      = r_err;
endmodule

// File: doc/fe_mul_share_arb.md
# fe_mul_share_arb

Parametrised round-robin arbiter that lets N field-element client blocks (ge_frombytes_negate_vartime, point add/double, and similar) share one fe_mulx instance. Each client issues a one-cycle multiply request. The arbiter captures that client's operands and serialises the requests onto the single multiplier's valid/done handshake. It then returns the product with a per-client done pulse. This replaces the point-to-point wiring in which one client owned fe_mulx outright.

## Interface
- N_CLIENTS, 4, number of requesting clients, 1..8
- W, 320, field-element width (10 x 32-bit limb packing)
- CW, max(1,clog2(N_CLIENTS)), owner index width (derived)

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- req_valid  in  N_CLIENTS  one-cycle request pulse per client
- req_op_a  in  N_CLIENTS*W  client i operand a at bits [i*W +: W]; sampled only with req_valid[i]
- req_op_b  in  N_CLIENTS*W  client i operand b, same packing
- req_done  out  N_CLIENTS  one-cycle pulse to the owning client
- req_res  out  W  registered product, broadcast; valid while req_done is high, held until the next completion
- mul_op_a  out  W  to fe_mulx op_a
- mul_op_b  out  W  to fe_mulx op_b
- mul_valid  out  1  one-cycle start pulse to fe_mulx
- mul_res  in  W  fe_mulx result
- mul_done  in  1  fe_mulx completion pulse
- busy  out  1  high in ISSUE or WAIT
- owner  out  CW  client currently granted; reset value 0
- err  out  1  sticky protocol-error flag

## Operation
- Per client: pending[i] bit plus captured cap_a[i], cap_b[i].
  - req_valid[i]=1 with pending[i]=0: pending[i] set, operands captured.
  - The client may change its operands from the next cycle on.
- Duplicate request (req_valid[i]=1 with pending[i]=1): ignored, captured operands unchanged, err set.
- FSM states:
  - IDLE: if any pending bit is set, grant the first pending client found searching upward from (rr+1) mod N_CLIENTS with wrap-around. owner <= grant, go to ISSUE. Otherwise stay.
  - ISSUE: mul_valid=1 for exactly this cycle; mul_op_a/b = cap_a/b[owner]; go to WAIT.
  - WAIT: mul_op_a/b held. On mul_done: req_res <= mul_res, req_done[owner] <= 1 (next cycle), pending[owner] cleared, rr <= owner, go to IDLE.
- rr resets to N_CLIENTS-1, so client 0 wins the first contention.
- Simultaneous events:
  - A new req_valid[j] in the same cycle as a grant is not in the search. It is considered at the next IDLE.
  - req_valid[owner] in the mul_done cycle is a duplicate, because pending is still set.
- mul_done in IDLE or ISSUE: ignored, err set.
- err is cleared only by reset.
- N_CLIENTS=1: degenerates to a pass-through with a registered result; rr logic is constant.
- No arithmetic is performed; widths pass through unchanged.

## Timing
- Reset (rst=0, asynchronous):
  - State IDLE, pending=0, rr=N_CLIENTS-1.
  - All outputs 0 (req_done, req_res, mul_*, busy, owner, err).
  - Captured operands 0.
  - An in-flight multiply is abandoned and no req_done is produced.
- Latency, with req_valid in cycle 0 and the arbiter idle:
  - pending visible in cycle 1, grant in cycle 1.
  - mul_valid in cycle 2.
  - mul_done at cycle k gives req_done and req_res at cycle k+1.
  - The next grant is also made in cycle k+1, so the next mul_valid is at k+2.
- Overhead: 2 cycles before and 1 cycle after each fe_mulx operation; only one multiply is in flight.
- Per-client ordering: a client may issue its next request from cycle k+1 (the cycle it sees req_done).
- Starvation bound: a pending client is served within N_CLIENTS-1 other grants.

## Test plan
- Single request: client 0 sends a=320'h2, b=320'h3 in cycle 0, with a fixed-latency fe_mulx model → mul_valid only in cycle 2, req_done=4'b0001 for one cycle, req_res=320'h6, err=0.
- Full contention: all four clients request in cycle 0 (client i: a=i+1, b=320'h1) → mul_valid order owner 0,1,2,3, req_res 1,2,3,4, one req_done pulse each. Repeat for a second round → order again 0,1,2,3.
- Pointer wrap: after only client 2 is served, clients 0 and 3 request together → client 3 granted first, then client 0.
- Operand capture: client 1 requests a=320'h5, b=320'h7, then drives garbage on the next cycle → fe_mulx sees 5 and 7, req_res=320'h23. Second vector: a=1, b=ge A.X limbs → req_res equals A.X.
- Protocol errors:
  - Duplicate req_valid[2] while pending → single mul_valid and single req_done, err=1.
  - Stray mul_done in IDLE → err=1, no req_done.
- Reset mid-operation: pull rst low in WAIT → all outputs 0 immediately, no req_done. After release, a new request from client 3 is served with the 2-cycle issue latency and owner=3.
